// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: RV32I load/store over a req/ack data port, with pass-through of other results.
// Optional macro MEM_ACCESS_MISALIGN_TRAP_EN turns misaligned accesses into single-cycle exceptions.
module mem_access_stage #(
  parameter logic [6:0] OP_LOAD  = 7'b0000011,
  parameter logic [6:0] OP_STORE = 7'b0100011
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        A_VALID,
  input  logic [31:0] A_PC,
  input  logic [31:0] A_INST,
  input  logic [4:0]  A_REG_D,
  input  logic [31:0] A_REG_D_V,
  input  logic [31:0] A_STORE_V,
  input  logic        A_DO_JMP,
  input  logic [31:0] A_NEW_PC,
  output logic        MEM_WAIT,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_WSTRB,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic        M_VALID,
  output logic [31:0] M_PC,
  output logic [31:0] M_INST,
  output logic [4:0]  M_REG_D,
  output logic [31:0] M_REG_D_V,
  output logic        M_EXC,
  output logic        DO_JMP,
  output logic [31:0] NEW_PC
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Handshake: MEM_REQ rises with the request fields and all of them hold
  // unchanged until the cycle MEM_ACK is sampled high; MEM_ACK outside BUSY is ignored.
  state_t      state_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_wstrb_q;
  logic [1:0]  addr_lo_q;
  logic        m_valid_q, jmp_q;
  logic [31:0] m_pc_q, m_inst_q, m_reg_d_v_q, new_pc_q;
  logic [4:0]  m_reg_d_q;

  logic [2:0]  f3_d;
  logic        is_load_d, is_store_d, ld_ok_d, st_ok_d;
  logic        misalign_d, issue_d, zero_rd_d, capture_d;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;

  always_comb begin
    f3_d       = A_INST[14:12];
    is_load_d  = (A_INST[6:0] == OP_LOAD);
    is_store_d = (A_INST[6:0] == OP_STORE);
    ld_ok_d    = is_load_d && (f3_d inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    st_ok_d    = is_store_d && (f3_d inside {3'b000, 3'b001, 3'b010});
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    misalign_d = (ld_ok_d || st_ok_d) &&
                 (((f3_d[1:0] == 2'b01) && A_REG_D_V[0]) ||
                  ((f3_d[1:0] == 2'b10) && (A_REG_D_V[1:0] != 2'b00)));
`else
    misalign_d = 1'b0;
`endif
    issue_d    = (ld_ok_d || st_ok_d) && !misalign_d;
    zero_rd_d  = is_store_d || (is_load_d && !issue_d);
    capture_d  = (state_q == IDLE) && A_VALID && !FLUSH;
    case (f3_d[1:0])
      2'b00: begin
        wstrb_d = 4'b0001 << A_REG_D_V[1:0];
        wdata_d = {4{A_STORE_V[7:0]}};
      end
      2'b01: begin
        wstrb_d = A_REG_D_V[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{A_STORE_V[15:0]}};
      end
      default: begin
        wstrb_d = 4'b1111;
        wdata_d = A_STORE_V;
      end
    endcase
  end

  // Load formatting works off the captured funct3 and low address bits.
  logic [31:0] rd_shift_d, load_d;
  logic [15:0] rd_half_d;
  always_comb begin
    rd_shift_d = MEM_RDATA >> {addr_lo_q, 3'b000};
    rd_half_d  = addr_lo_q[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
    case (m_inst_q[14:12])
      3'b000:  load_d = {{24{rd_shift_d[7]}}, rd_shift_d[7:0]};
      3'b001:  load_d = {{16{rd_half_d[15]}}, rd_half_d};
      3'b100:  load_d = {24'b0, rd_shift_d[7:0]};
      3'b101:  load_d = {16'b0, rd_half_d};
      default: load_d = MEM_RDATA;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      addr_lo_q   <= '0;
      m_valid_q   <= 1'b0;
      m_pc_q      <= '0;
      m_inst_q    <= '0;
      m_reg_d_q   <= '0;
      m_reg_d_v_q <= '0;
      jmp_q       <= 1'b0;
      new_pc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture_d) begin
            m_pc_q      <= A_PC;
            m_inst_q    <= A_INST;
            m_reg_d_v_q <= A_REG_D_V;
            m_reg_d_q   <= zero_rd_d ? 5'd0 : A_REG_D;
            jmp_q       <= A_DO_JMP;
            new_pc_q    <= A_NEW_PC;
            addr_lo_q   <= A_REG_D_V[1:0];
            if (issue_d) begin
              state_q     <= BUSY;
              mem_req_q   <= 1'b1;
              mem_we_q    <= st_ok_d;
              mem_addr_q  <= {A_REG_D_V[31:2], 2'b00};
              mem_wstrb_q <= st_ok_d ? wstrb_d : 4'b0000;
              mem_wdata_q <= st_ok_d ? wdata_d : 32'd0;
              m_valid_q   <= 1'b0;
            end else begin
              m_valid_q   <= 1'b1;
            end
          end else begin
            m_valid_q <= 1'b0;
          end
        end
        BUSY: begin
          if (MEM_ACK) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            m_valid_q <= 1'b1;
            if (!mem_we_q) m_reg_d_v_q <= load_d;
          end else begin
            m_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic m_exc_q;
  always_ff @(posedge CLK) begin
    if (RST || (state_q == BUSY)) m_exc_q <= 1'b0;
    else                          m_exc_q <= capture_d && misalign_d;
  end
  assign M_EXC = m_exc_q;
`else
  assign M_EXC = 1'b0;
`endif

  // The FSM state is directly observable on MEM_WAIT.
  assign MEM_WAIT  = (state_q == BUSY);
  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WSTRB = mem_wstrb_q;
  assign MEM_WDATA = mem_wdata_q;
  assign M_VALID   = m_valid_q;
  assign M_PC      = m_pc_q;
  assign M_INST    = m_inst_q;
  assign M_REG_D   = m_reg_d_q;
  assign M_REG_D_V = m_reg_d_v_q;
  assign DO_JMP    = m_valid_q & jmp_q;
  assign NEW_PC    = new_pc_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: hand-computed expectations, immediate assertions, one summary line.
module tb_mem_access_stage;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_ALU = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic        CLK = 1'b0;
  logic        RST, FLUSH, A_VALID, A_DO_JMP, MEM_ACK;
  logic [31:0] A_PC, A_INST, A_REG_D_V, A_STORE_V, A_NEW_PC, MEM_RDATA;
  logic [4:0]  A_REG_D;
  logic        MEM_WAIT, MEM_REQ, MEM_WE, M_VALID, M_EXC, DO_JMP;
  logic [31:0] MEM_ADDR, MEM_WDATA, M_PC, M_INST, M_REG_D_V, NEW_PC;
  logic [3:0]  MEM_WSTRB;
  logic [4:0]  M_REG_D;

  int total = 0;
  int bad = 0;
  int busy_cnt;

  mem_access_stage dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .A_VALID(A_VALID), .A_PC(A_PC), .A_INST(A_INST),
    .A_REG_D(A_REG_D), .A_REG_D_V(A_REG_D_V), .A_STORE_V(A_STORE_V), .A_DO_JMP(A_DO_JMP),
    .A_NEW_PC(A_NEW_PC), .MEM_WAIT(MEM_WAIT), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WSTRB(MEM_WSTRB), .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK),
    .MEM_RDATA(MEM_RDATA), .M_VALID(M_VALID), .M_PC(M_PC), .M_INST(M_INST), .M_REG_D(M_REG_D),
    .M_REG_D_V(M_REG_D_V), .M_EXC(M_EXC), .DO_JMP(DO_JMP), .NEW_PC(NEW_PC)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
    return {17'd0, f3, rd, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one instruction for a single capture edge, then withdraw it.
  task automatic issue(input logic [31:0] ins, input logic [4:0] rd, input logic [31:0] v,
                       input logic [31:0] sv);
    A_INST = ins; A_REG_D = rd; A_REG_D_V = v; A_STORE_V = sv;
    A_PC = A_PC + 32'd4; A_VALID = 1'b1;
    @(negedge CLK);
    A_VALID = 1'b0;
  endtask

  // Memory responder: acks after 'waits' idle cycles, counting cycles with MEM_WAIT high.
  task automatic mem_ack(input int waits, input logic [31:0] rdata);
    busy_cnt = 0;
    for (int i = 0; i <= waits; i++) begin
      if (MEM_WAIT) busy_cnt++;
      if (i == waits) begin
        MEM_ACK = 1'b1; MEM_RDATA = rdata;
      end
      @(negedge CLK);
      MEM_ACK = 1'b0;
    end
  endtask

  initial begin
    RST = 1'b1; FLUSH = 1'b0; A_VALID = 1'b0; A_DO_JMP = 1'b0; MEM_ACK = 1'b0;
    A_PC = 32'h1000; A_INST = '0; A_REG_D = '0; A_REG_D_V = '0; A_STORE_V = '0;
    A_NEW_PC = '0; MEM_RDATA = '0;
    repeat (2) @(negedge CLK);
    chk("rst_wait", MEM_WAIT, 0);
    chk("rst_req", MEM_REQ, 0);
    chk("rst_valid", M_VALID, 0);
    chk("rst_jmp", DO_JMP, 0);
    chk("rst_addr", MEM_ADDR, 0);
    chk("rst_regdv", M_REG_D_V, 0);
    RST = 1'b0;
    @(negedge CLK);

    // addi pass-through
    issue(mk_inst(OP_ALU, 3'b000, 5'd5), 5'd5, 32'h3E8, 0);
    chk("alu_valid", M_VALID, 1);
    chk("alu_rd", M_REG_D, 5);
    chk("alu_val", M_REG_D_V, 32'h3E8);
    chk("alu_req", MEM_REQ, 0);
    chk("alu_pc", M_PC, 32'h1004);
    @(negedge CLK);
    chk("alu_pulse", M_VALID, 0);

    // taken jump on non-memory instruction
    A_DO_JMP = 1'b1; A_NEW_PC = 32'h400;
    issue(mk_inst(OP_JAL, 3'b000, 5'd1), 5'd1, 32'h1010, 0);
    A_DO_JMP = 1'b0; A_NEW_PC = 32'h0;
    chk("jmp_do", DO_JMP, 1);
    chk("jmp_pc", NEW_PC, 32'h400);
    @(negedge CLK);
    chk("jmp_pulse", DO_JMP, 0);

    // LB 0x103 with three wait cycles
    issue(mk_inst(OP_LD, 3'b000, 5'd7), 5'd7, 32'h103, 0);
    chk("lb_req", MEM_REQ, 1);
    chk("lb_addr", MEM_ADDR, 32'h100);
    chk("lb_we", MEM_WE, 0);
    chk("lb_nvalid", M_VALID, 0);
    mem_ack(3, 32'h80FF_0000);
    chk("lb_busy", busy_cnt, 4);
    chk("lb_valid", M_VALID, 1);
    chk("lb_rd", M_REG_D, 7);
    chk("lb_val", M_REG_D_V, 32'hFFFF_FF80);
    chk("lb_wait_end", MEM_WAIT, 0);
    chk("lb_req_end", MEM_REQ, 0);

    // SH 0x22
    issue(mk_inst(OP_ST, 3'b001, 5'd9), 5'd9, 32'h22, 32'h1234_ABCD);
    chk("sh_we", MEM_WE, 1);
    chk("sh_strb", MEM_WSTRB, 4'b1100);
    chk("sh_wdata", MEM_WDATA, 32'hABCD_ABCD);
    chk("sh_addr", MEM_ADDR, 32'h20);
    mem_ack(0, 32'h0);
    chk("sh_valid", M_VALID, 1);
    chk("sh_rd", M_REG_D, 0);

    // SB 0x13
    issue(mk_inst(OP_ST, 3'b000, 5'd1), 5'd1, 32'h13, 32'hAA55_66EE);
    chk("sb_strb", MEM_WSTRB, 4'b1000);
    chk("sb_wdata", MEM_WDATA, 32'hEEEE_EEEE);
    chk("sb_addr", MEM_ADDR, 32'h10);
    mem_ack(0, 32'h0);

    // LBU byte 1
    issue(mk_inst(OP_LD, 3'b100, 5'd8), 5'd8, 32'h201, 0);
    mem_ack(1, 32'h0000_F200);
    chk("lbu_val", M_REG_D_V, 32'h0000_00F2);

    // LH upper half while upstream holds the next instruction
    issue(mk_inst(OP_LD, 3'b001, 5'd10), 5'd10, 32'h302, 0);
    A_INST = mk_inst(OP_ALU, 3'b000, 5'd11); A_REG_D = 5'd11; A_REG_D_V = 32'h77; A_VALID = 1'b1;
    mem_ack(2, 32'h8001_1234);
    chk("lh_valid", M_VALID, 1);
    chk("lh_rd", M_REG_D, 10);
    chk("lh_val", M_REG_D_V, 32'hFFFF_8001);
    @(negedge CLK);
    A_VALID = 1'b0;
    chk("held_valid", M_VALID, 1);
    chk("held_rd", M_REG_D, 11);
    chk("held_val", M_REG_D_V, 32'h77);
    @(negedge CLK);
    chk("held_once", M_VALID, 0);

    // LHU lower half
    issue(mk_inst(OP_LD, 3'b101, 5'd12), 5'd12, 32'h300, 0);
    mem_ack(0, 32'h0000_9ABC);
    chk("lhu_val", M_REG_D_V, 32'h0000_9ABC);

    // invalid load funct3
    issue(mk_inst(OP_LD, 3'b011, 5'd6), 5'd6, 32'h40, 0);
    chk("inv_valid", M_VALID, 1);
    chk("inv_req", MEM_REQ, 0);
    chk("inv_rd", M_REG_D, 0);
    chk("inv_val", M_REG_D_V, 32'h40);
    @(negedge CLK);

    // FLUSH in IDLE blocks capture
    FLUSH = 1'b1;
    issue(mk_inst(OP_ALU, 3'b000, 5'd4), 5'd4, 32'h1, 0);
    FLUSH = 1'b0;
    chk("flush_idle", M_VALID, 0);

    // FLUSH in BUSY is ignored
    issue(mk_inst(OP_LD, 3'b010, 5'd2), 5'd2, 32'h80, 0);
    FLUSH = 1'b1;
    mem_ack(1, 32'hCAFE_F00D);
    FLUSH = 1'b0;
    chk("flush_busy_valid", M_VALID, 1);
    chk("flush_busy_val", M_REG_D_V, 32'hCAFE_F00D);

    // LW at 0x6
    issue(mk_inst(OP_LD, 3'b010, 5'd13), 5'd13, 32'h6, 0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    chk("mis_exc", M_EXC, 1);
    chk("mis_req", MEM_REQ, 0);
    chk("mis_valid", M_VALID, 1);
    chk("mis_rd", M_REG_D, 0);
    chk("mis_val", M_REG_D_V, 32'h6);
    @(negedge CLK);
    chk("mis_exc_once", M_EXC, 0);
`else
    chk("lw6_addr", MEM_ADDR, 32'h4);
    chk("lw6_req", MEM_REQ, 1);
    chk("lw6_exc", M_EXC, 0);
    mem_ack(0, 32'hDEAD_BEEF);
    chk("lw6_val", M_REG_D_V, 32'hDEAD_BEEF);
    chk("lw6_rd", M_REG_D, 13);
`endif

    // reset during an outstanding access
    issue(mk_inst(OP_LD, 3'b010, 5'd3), 5'd3, 32'h40, 0);
    chk("rstb_req", MEM_REQ, 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rstb_req_drop", MEM_REQ, 0);
    chk("rstb_wait", MEM_WAIT, 0);
    chk("rstb_valid", M_VALID, 0);
    MEM_ACK = 1'b1; MEM_RDATA = 32'h1234_5678;
    @(negedge CLK);
    MEM_ACK = 1'b0;
    chk("late_ack_valid", M_VALID, 0);
    chk("late_ack_wait", MEM_WAIT, 0);
    chk("late_ack_req", MEM_REQ, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
